// File: rtl/ahb3lite_pkg.sv
`default_nettype none
// ahb3lite_pkg: shared AHB3-Lite encodings plus CSR access-mode and error-FSM types.
// Rev 1.0
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [31:0] CSR_BADADDR = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    CSR_RW  = 3'd0,
    CSR_RO  = 3'd1,
    CSR_WO  = 3'd2,
    CSR_W1C = 3'd3,
    CSR_W1S = 3'd4,
    CSR_RC  = 3'd5
  } csr_access_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } csr_err_state_t;

  // RO and the reserved encodings 6/7 never take software writes.
  function automatic logic fixed_mode(input logic [2:0] mode);
    return (mode == CSR_RO) || (mode > CSR_RC);
  endfunction

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb3lite_csr2_reg.sv
`default_nettype none
// ahb3lite_csr2_reg: one CSR cell - mode decode, byte-masked update, HW set merge, REGOUT mux.
// Rev 1.0
module ahb3lite_csr2_reg
  import ahb3lite_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  access,
  input  logic [31:0] regin,
  input  logic [31:0] hwset,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] store,
  output logic [31:0] regout
);

  logic [31:0] bmask;
  logic [31:0] wmask;
  logic [31:0] store_nxt;

  always_comb begin
    bmask     = be_to_mask(be);
    wmask     = wdata & bmask;
    store_nxt = store;
    if (wr_en) begin
      case (access)
        CSR_RW, CSR_WO: store_nxt = (store & ~bmask) | wmask;
        CSR_W1C:        store_nxt = store & ~wmask;
        CSR_W1S:        store_nxt = store | wmask;
        default:        store_nxt = store;
      endcase
    end
    if (rd_en && (access == CSR_RC)) store_nxt = 32'h0;
    // HW set is merged last so it wins over a same-cycle clear.
    if ((access == CSR_W1C) || (access == CSR_RC)) store_nxt = store_nxt | hwset;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      store  <= regin;
      regout <= regin;
    end else begin
      store  <= store_nxt;
      regout <= fixed_mode(access) ? regin : store_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb3lite_csr2.sv
`default_nettype none
// ahb3lite_csr2: AHB3-Lite CSR slave, CNT registers with run-time access modes and strobes.
// Optional two-cycle ERROR response with macro AHB3LITE_CSR2_ERR_EN. Rev 1.0
module ahb3lite_csr2
  import ahb3lite_pkg::*;
#(
  parameter int CNT = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [31:0]           HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  input  logic [CNT-1:0][2:0]   ACCESS,
  input  logic [CNT-1:0][31:0]  REGIN,
  input  logic [CNT-1:0][31:0]  HWSET,
  output logic [CNT-1:0][31:0]  REGOUT,
  output logic [CNT-1:0]        WSTB,
  output logic [CNT-1:0]        RSTB
);

  localparam int IDX_W = $clog2(CNT);

  logic [IDX_W-1:0]     a_idx;
  logic                 a_oob;
  logic                 a_acc;
  logic                 a_err;
  logic [3:0]           a_be;
  logic                 dp_valid;
  logic                 dp_write;
  logic                 dp_oob;
  logic [IDX_W-1:0]     dp_idx;
  logic [3:0]           dp_be;
  logic                 commit;
  logic [CNT-1:0]       wr_en;
  logic [CNT-1:0]       rd_en;
  logic [CNT-1:0]       wr_ok;
  logic [CNT-1:0][31:0] reg_store;
  csr_err_state_t       err_state;
  logic                 unused;

  assign unused = ^{HPROT, HBURST};
  assign a_idx  = HADDR[IDX_W+1:2];
  assign a_oob  = HADDR[31:2] >= 30'(CNT);
  assign a_acc  = HSEL && HREADY && (err_state != ST_ERR1) &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  always_comb begin
    case (HSIZE)
      HSIZE_BYTE: a_be = 4'h1 << HADDR[1:0];
      HSIZE_HALF: a_be = 4'h3 << {HADDR[1], 1'b0};
      default:    a_be = 4'hF;
    endcase
  end

`ifdef AHB3LITE_CSR2_ERR_EN
  assign a_err = a_oob || (HSIZE > HSIZE_WORD) || (HWRITE && fixed_mode(ACCESS[a_idx]));
`else
  assign a_err = 1'b0;
`endif

  // Erroring transfers never enter the data-phase latch, so they cannot commit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_oob   <= 1'b0;
      dp_idx   <= '0;
      dp_be    <= '0;
    end else if (HREADY) begin
      dp_valid <= a_acc && !a_err;
      dp_write <= HWRITE;
      dp_oob   <= a_oob;
      dp_idx   <= a_idx;
      dp_be    <= a_be;
    end
  end

  assign commit = dp_valid && HREADY && !dp_oob;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_state <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      case (err_state)
        ST_ERR1: begin
          err_state <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          if (a_acc && a_err) begin
            err_state <= ST_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end else begin
            err_state <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      WSTB <= '0;
      RSTB <= '0;
    end else begin
      WSTB <= wr_en & wr_ok;
      RSTB <= rd_en;
    end
  end

  always_comb begin
    HRDATA = 32'h0;
    if (dp_valid) begin
      if (dp_oob) begin
        HRDATA = CSR_BADADDR;
      end else begin
        case (ACCESS[dp_idx])
          CSR_RO:  HRDATA = REGIN[dp_idx];
          CSR_WO:  HRDATA = 32'h0;
          default: HRDATA = reg_store[dp_idx];
        endcase
      end
    end
  end

  for (genvar g = 0; g < CNT; g++) begin : g_reg
    assign wr_en[g] = commit && dp_write && (dp_idx == IDX_W'(g));
    assign rd_en[g] = commit && !dp_write && (dp_idx == IDX_W'(g));
    assign wr_ok[g] = !fixed_mode(ACCESS[g]);

    ahb3lite_csr2_reg u_reg (
      .clk    (CLK),
      .rst    (RESET),
      .access (ACCESS[g]),
      .regin  (REGIN[g]),
      .hwset  (HWSET[g]),
      .wr_en  (wr_en[g]),
      .rd_en  (rd_en[g]),
      .wdata  (HWDATA),
      .be     (dp_be),
      .store  (reg_store[g]),
      .regout (REGOUT[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb3lite_csr2.sv
`default_nettype none
// tb_ahb3lite_csr2: randomized self-checking bench with a behavioural register model.
// Rev 1.0
module tb_ahb3lite_csr2;

  localparam int CNT = 8;
`ifdef AHB3LITE_CSR2_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  logic                  hsel;
  logic [31:0]           haddr;
  logic [31:0]           hwdata;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic [1:0]            htrans;
  logic                  hready;
  logic [31:0]           hrdata;
  logic                  hreadyout;
  logic                  hresp;
  logic [CNT-1:0][2:0]   access;
  logic [CNT-1:0][31:0]  regin;
  logic [CNT-1:0][31:0]  hwset;
  logic [CNT-1:0][31:0]  regout;
  logic [CNT-1:0]        wstb;
  logic [CNT-1:0]        rstb;

  int pass_cnt = 0;
  int total    = 0;

  assign hready = hreadyout;

  ahb3lite_csr2 #(.CNT(CNT)) dut (
    .CLK(clk), .RESET(rst), .HSEL(hsel), .HADDR(haddr), .HWDATA(hwdata),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HREADY(hready), .HRDATA(hrdata), .HREADYOUT(hreadyout),
    .HRESP(hresp), .ACCESS(access), .REGIN(regin), .HWSET(hwset),
    .REGOUT(regout), .WSTB(wstb), .RSTB(rstb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [31:0] a, input logic [2:0] sz, input logic wr);
    hsel = 1'b1; haddr = a; hsize = sz; hwrite = wr; htrans = 2'b10;
  endtask

  task automatic set_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!hreadyout && n < 8) begin
      tick();
      n++;
    end
    if (!hreadyout) begin
      total++;
      $display("FAIL ready_timeout: hreadyout=%b want 1", hreadyout);
    end
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    set_addr(a, sz, 1'b1);
    tick();
    set_idle();
    hwdata = d;
    wait_ready();
    tick();
  endtask

  task automatic ahb_read(input logic [31:0] a, input logic [2:0] sz,
                          output logic [31:0] rd, output logic rsp);
    set_addr(a, sz, 1'b0);
    tick();
    set_idle();
    wait_ready();
    rd  = hrdata;
    rsp = hresp;
    tick();
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        rsp;
    do_reset();
    for (int i = 0; i < CNT; i++) begin
      total++;
      if (regout[i] !== regin[i]) $display("FAIL reset_regout%0d: got %h want %h", i, regout[i], regin[i]);
      else pass_cnt++;
    end
    total++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0) $display("FAIL reset_resp: got ready=%b resp=%b want 1/0", hreadyout, hresp);
    else pass_cnt++;
    total++;
    if (wstb !== '0 || rstb !== '0 || hrdata !== 32'h0) $display("FAIL reset_outs: got wstb=%h rstb=%h hrdata=%h want 0", wstb, rstb, hrdata);
    else pass_cnt++;
    ahb_read(32'h0, 3'd2, rd, rsp);
    total++;
    if (rd !== 32'h1234_5678 || rsp !== 1'b0) $display("FAIL reset_read0: got %h resp=%b want 12345678/0", rd, rsp);
    else pass_cnt++;
    total++;
    if (rstb !== 8'h01) $display("FAIL reset_rstb0: got %h want 01", rstb);
    else pass_cnt++;
  endtask

  task automatic test_byte_write();
    set_addr(32'h5, 3'd0, 1'b1);
    tick();
    hwdata = 32'h0000_AB00;
    set_addr(32'h4, 3'd2, 1'b0);
    tick();
    total++;
    if (hrdata !== 32'h0000_AB00) $display("FAIL b2b_read: got %h want 0000ab00", hrdata);
    else pass_cnt++;
    total++;
    if (regout[1] !== 32'h0000_AB00) $display("FAIL byte_regout: got %h want 0000ab00", regout[1]);
    else pass_cnt++;
    total++;
    if (wstb !== 8'h02) $display("FAIL byte_wstb: got %h want 02", wstb);
    else pass_cnt++;
    set_idle();
    tick();
    total++;
    if (wstb !== 8'h00 || rstb !== 8'h02) $display("FAIL byte_strobes: got wstb=%h rstb=%h want 00/02", wstb, rstb);
    else pass_cnt++;
  endtask

  task automatic test_w1c();
    logic [31:0] rd;
    logic        rsp;
    access[2] = 3'd3;
    ahb_write(32'h8, 3'd2, 32'hFFFF_FFFF);
    hwset[2] = 32'hF;
    tick();
    hwset[2] = 32'h0;
    tick();
    total++;
    if (regout[2] !== 32'hF) $display("FAIL w1c_set: got %h want 0000000f", regout[2]);
    else pass_cnt++;
    set_addr(32'h8, 3'd2, 1'b1);
    tick();
    set_idle();
    hwdata   = 32'h3;
    hwset[2] = 32'h1;
    tick();
    hwset[2] = 32'h0;
    total++;
    if (regout[2] !== 32'hD || wstb !== 8'h04) $display("FAIL w1c_clear: got %h wstb=%h want 0000000d/04", regout[2], wstb);
    else pass_cnt++;
    ahb_read(32'h8, 3'd2, rd, rsp);
    total++;
    if (rd !== 32'hD) $display("FAIL w1c_read: got %h want 0000000d", rd);
    else pass_cnt++;
  endtask

  task automatic test_rc();
    logic [31:0] rd;
    logic        rsp;
    access[3] = 3'd5;
    ahb_read(32'hC, 3'd2, rd, rsp);
    hwset[3] = 32'h80;
    tick();
    hwset[3] = 32'h0;
    ahb_read(32'hC, 3'd2, rd, rsp);
    total++;
    if (rd !== 32'h80) $display("FAIL rc_read: got %h want 00000080", rd);
    else pass_cnt++;
    total++;
    if (rstb !== 8'h08 || wstb !== 8'h00) $display("FAIL rc_rstb: got rstb=%h wstb=%h want 08/00", rstb, wstb);
    else pass_cnt++;
    ahb_read(32'hC, 3'd2, rd, rsp);
    total++;
    if (rd !== 32'h0) $display("FAIL rc_reread: got %h want 0", rd);
    else pass_cnt++;
  endtask

  task automatic test_oob();
    logic [31:0] rd;
    logic        rsp;
    logic [31:0] before0;
    before0 = regout[0];
    if (ERR_BUILD) begin
      set_addr(32'h20, 3'd2, 1'b1);
      tick();
      set_idle();
      hwdata = 32'hCAFE_F00D;
      total++;
      if (hreadyout !== 1'b0 || hresp !== 1'b1) $display("FAIL err_cycle1: got ready=%b resp=%b want 0/1", hreadyout, hresp);
      else pass_cnt++;
      tick();
      total++;
      if (hreadyout !== 1'b1 || hresp !== 1'b1) $display("FAIL err_cycle2: got ready=%b resp=%b want 1/1", hreadyout, hresp);
      else pass_cnt++;
      tick();
      total++;
      if (wstb !== 8'h00 || hresp !== 1'b0) $display("FAIL err_after: got wstb=%h resp=%b want 00/0", wstb, hresp);
      else pass_cnt++;
    end else begin
      ahb_read(32'h20, 3'd2, rd, rsp);
      total++;
      if (rd !== 32'hDEAD_BEEF || rsp !== 1'b0) $display("FAIL oob_read: got %h resp=%b want deadbeef/0", rd, rsp);
      else pass_cnt++;
      total++;
      if (rstb !== 8'h00) $display("FAIL oob_rstb: got %h want 00", rstb);
      else pass_cnt++;
      ahb_write(32'h20, 3'd2, 32'hCAFE_F00D);
      total++;
      if (wstb !== 8'h00) $display("FAIL oob_wstb: got %h want 00", wstb);
      else pass_cnt++;
    end
    // Oversized transfer: plain word write without the error option, ERROR with it.
    ahb_write(32'h0, 3'd3, 32'h0BAD_F00D);
    total++;
    if (regout[0] !== (ERR_BUILD ? before0 : 32'h0BAD_F00D))
      $display("FAIL big_size: got %h want %h", regout[0], ERR_BUILD ? before0 : 32'h0BAD_F00D);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    ahb_write(32'h0, 3'd2, 32'h55AA_55AA);
    total++;
    if (regout[0] !== 32'h55AA_55AA) $display("FAIL pre_reset_wr: got %h want 55aa55aa", regout[0]);
    else pass_cnt++;
    set_addr(32'h0, 3'd2, 1'b1);
    tick();
    set_idle();
    hwdata = 32'h1111_2222;
    rst    = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (regout[0] !== regin[0] || wstb !== 8'h00) $display("FAIL mid_reset: got %h wstb=%h want %h/00", regout[0], wstb, regin[0]);
    else pass_cnt++;
    tick();
    total++;
    if (regout[0] !== regin[0] || wstb !== 8'h00) $display("FAIL mid_reset_after: got %h wstb=%h want %h/00", regout[0], wstb, regin[0]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] mstore [CNT];
    int          idx;
    logic [2:0]  m;
    logic        wr;
    logic [2:0]  sz;
    logic [1:0]  off;
    logic [31:0] lanes;
    logic [31:0] d;
    logic [31:0] rd;
    logic [31:0] exp;
    logic        rsp;
    logic        fixed;
    logic [CNT-1:0] exp_stb;
    do_reset();
    for (int i = 0; i < CNT; i++) mstore[i] = regin[i];
    for (int t = 0; t < 150; t++) begin
      idx   = $urandom_range(0, CNT-1);
      m     = 3'($urandom_range(0, 7));
      wr    = 1'($urandom_range(0, 1));
      sz    = 3'($urandom_range(0, 2));
      off   = (sz == 3'd0) ? 2'($urandom_range(0, 3)) :
              (sz == 3'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      lanes = (sz == 3'd0) ? (32'hFF << (8 * off)) :
              (sz == 3'd1) ? (32'hFFFF << (8 * off)) : 32'hFFFF_FFFF;
      fixed = (m == 3'd1) || (m >= 3'd6);
      access[idx] = m;
      exp_stb = '0;
      if (wr) begin
        d = $urandom;
        ahb_write({26'h0, 4'(idx), off}, sz, d);
        case (m)
          3'd0, 3'd2: mstore[idx] = (mstore[idx] & ~lanes) | (d & lanes);
          3'd3:       mstore[idx] = mstore[idx] & ~(d & lanes);
          3'd4:       mstore[idx] = mstore[idx] | (d & lanes);
          default:    ;
        endcase
        if (!fixed) exp_stb[idx] = 1'b1;
        total++;
        if (wstb !== exp_stb) $display("FAIL rnd_wstb t%0d: got %h want %h (mode %0d)", t, wstb, exp_stb, m);
        else pass_cnt++;
      end else begin
        ahb_read({26'h0, 4'(idx), off}, sz, rd, rsp);
        exp = (m == 3'd1) ? regin[idx] : (m == 3'd2) ? 32'h0 : mstore[idx];
        if (m == 3'd5) mstore[idx] = 32'h0;
        exp_stb[idx] = 1'b1;
        total++;
        if (rd !== exp || rsp !== 1'b0) $display("FAIL rnd_read t%0d idx%0d: got %h resp=%b want %h (mode %0d)", t, idx, rd, rsp, exp, m);
        else pass_cnt++;
        total++;
        if (rstb !== exp_stb) $display("FAIL rnd_rstb t%0d: got %h want %h", t, rstb, exp_stb);
        else pass_cnt++;
      end
      exp = fixed ? regin[idx] : mstore[idx];
      total++;
      if (regout[idx] !== exp) $display("FAIL rnd_regout t%0d idx%0d: got %h want %h (mode %0d)", t, idx, regout[idx], exp, m);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; hsel = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0;
    hsize = 3'd2; hburst = 3'd0; hprot = 4'h3; htrans = 2'b00;
    hwset = '0;
    for (int i = 0; i < CNT; i++) begin
      access[i] = 3'd0;
      regin[i]  = $urandom;
    end
    regin[0] = 32'h1234_5678;
    regin[1] = 32'h0;
    test_reset();
    test_byte_write();
    test_w1c();
    test_rc();
    test_oob();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire
